// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the writeback-source arbiter.
package wb_arb_pkg;

  localparam int SRC_ALU   = 0;
  localparam int SRC_LOAD  = 1;
  localparam int SRC_PC4   = 2;
  localparam int SRC_PCIMM = 3;
  localparam int SRC_IMM   = 4;

  localparam int DEF_STARVE_LIMIT = 4;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/wb_prio_pick.sv
// Highest-set-bit picker: reports whether any bit of mask is set and its top index.
module wb_prio_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 5,
  localparam int IW = sel_w(N)
) (
  input  logic [N-1:0]  mask,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    any = |mask;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Fixed-priority (highest index wins) writeback arbiter feeding one registered regfile write port.
// Define WB_ARB_AGE_EN to add per-source aging that forces starved sources through.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_SRC      = 5,
  parameter int DATA_W       = 32,
  parameter int RD_W         = 5,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int SEL_W = sel_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*RD_W-1:0]   src_rd,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      wb_valid,
  output logic [SEL_W-1:0]          wb_sel,
  output logic [DATA_W-1:0]         wb_data,
  output logic [RD_W-1:0]           wb_rd,
  input  logic                      wb_ready
);

  logic                wb_valid_reg;
  logic [SEL_W-1:0]    wb_sel_reg;
  logic [DATA_W-1:0]   wb_data_reg;
  logic [RD_W-1:0]     wb_rd_reg;

  logic                load;
  logic [NUM_SRC-1:0]  req;
  logic                req_any;
  logic [SEL_W-1:0]    req_idx;
  logic                gnt;
  logic [SEL_W-1:0]    gnt_idx;
  logic [DATA_W-1:0]   gnt_data;
  logic [RD_W-1:0]     gnt_rd;

  // Requests are masked during reset so nothing is accepted while rst is high.
  assign load = !wb_valid_reg || wb_ready;
  assign req  = rst ? '0 : src_valid;
  assign gnt  = load && req_any;

  wb_prio_pick #(.N(NUM_SRC)) u_req_pick (
    .mask (req),
    .any  (req_any),
    .idx  (req_idx)
  );

  genvar gi;

`ifdef WB_ARB_AGE_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [NUM_SRC-1:0] starved;
  logic               starve_any;
  logic [SEL_W-1:0]   starve_idx;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_age
      logic [AGE_W-1:0] age_reg;

      assign starved[gi] = req[gi] && (age_reg == AGE_MAX);

      // Ages only advance on cycles where a grant could have been issued.
      always_ff @(posedge clk) begin
        if (rst || !src_valid[gi]) begin
          age_reg <= '0;
        end else if (gnt && (gnt_idx == SEL_W'(gi))) begin
          age_reg <= '0;
        end else if (load && (age_reg != AGE_MAX)) begin
          age_reg <= age_reg + 1'b1;
        end
      end
    end
  endgenerate

  wb_prio_pick #(.N(NUM_SRC)) u_starve_pick (
    .mask (starved),
    .any  (starve_any),
    .idx  (starve_idx)
  );

  assign gnt_idx = starve_any ? starve_idx : req_idx;
`else
  assign gnt_idx = req_idx;
`endif

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign src_ready[gi] = gnt && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    gnt_rd   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = src_data[i*DATA_W +: DATA_W];
        gnt_rd   = src_rd[i*RD_W +: RD_W];
      end
    end
  end

  // A grant with rd==0 is consumed but leaves the write port idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_sel_reg   <= '0;
      wb_data_reg  <= '0;
      wb_rd_reg    <= '0;
    end else if (load) begin
      if (gnt && (gnt_rd != '0)) begin
        wb_valid_reg <= 1'b1;
        wb_sel_reg   <= gnt_idx;
        wb_data_reg  <= gnt_data;
        wb_rd_reg    <= gnt_rd;
      end else begin
        wb_valid_reg <= 1'b0;
      end
    end
  end

  assign wb_valid = wb_valid_reg;
  assign wb_sel   = wb_sel_reg;
  assign wb_data  = wb_data_reg;
  assign wb_rd    = wb_rd_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter against a cycle-level behavioural model.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int N   = 5;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int LIM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    sv;
  logic [DW-1:0]   sd [N];
  logic [RW-1:0]   sr [N];
  logic [N*DW-1:0] src_data;
  logic [N*RW-1:0] src_rd;
  logic [N-1:0]    src_ready;
  logic            wb_valid;
  logic [2:0]      wb_sel;
  logic [DW-1:0]   wb_data;
  logic [RW-1:0]   wb_rd;
  logic            wb_ready;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_data[i*DW +: DW] = sd[i];
      src_rd[i*RW +: RW]   = sr[i];
    end
  end

  wb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .RD_W(RW), .STARVE_LIMIT(LIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (sv),
    .src_data  (src_data),
    .src_rd    (src_rd),
    .src_ready (src_ready),
    .wb_valid  (wb_valid),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_ready  (wb_ready)
  );

  int npass  = 0;
  int ntotal = 0;

  // Behavioural model state
  bit            m_valid;
  int            m_sel;
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_rd;
  int            age [N];
  logic [N-1:0]  last_gnt;
  logic [N-1:0]  last_dut_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    int g;
    int gs;
    bit ld;
    logic [N-1:0] er;
    @(negedge clk);
    ld = !m_valid || wb_ready;
    g  = -1;
    gs = -1;
    if (!rst && ld) begin
      for (int i = 0; i < N; i++) if (sv[i]) g = i;
`ifdef WB_ARB_AGE_EN
      for (int i = 0; i < N; i++) if (sv[i] && age[i] >= LIM) gs = i;
      if (gs >= 0) g = gs;
`endif
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("src_ready", src_ready, er);
    check("wb_valid", wb_valid, m_valid);
    check("wb_sel", wb_sel, m_sel);
    check("wb_data", wb_data, m_data);
    check("wb_rd", wb_rd, m_rd);
    last_gnt       = er;
    last_dut_ready = src_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_sel = 0; m_data = '0; m_rd = '0;
      for (int i = 0; i < N; i++) age[i] = 0;
    end else begin
      if (ld) begin
        if (g >= 0 && sr[g] != 0) begin
          m_valid = 1; m_sel = g; m_data = sd[g]; m_rd = sr[g];
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!sv[i] || g == i) age[i] = 0;
        else if (ld && age[i] < LIM) age[i] = age[i] + 1;
      end
    end
    #1;
  endtask

  int first0;

  initial begin
    m_valid = 0; m_sel = 0; m_data = '0; m_rd = '0;
    for (int i = 0; i < N; i++) begin
      age[i] = 0;
      sd[i]  = 32'h100 + i;
      sr[i]  = RW'(i + 1);
    end

    // 1: reset with every source requesting
    rst = 1'b1; wb_ready = 1'b0; sv = 5'b11111;
    repeat (2) cycle();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_sel", wb_sel, 0);
    check("rst_wb_data", wb_data, 0);
    rst = 1'b0; sv = '0;
    cycle();

    // 2: two requesters, higher index first
    sv = 5'b01010; sr[1] = 7; sr[3] = 7; sd[1] = 32'h1111; sd[3] = 32'h3333; wb_ready = 1'b1;
    cycle();
    check("t2_ready3", last_dut_ready, 5'b01000);
    check("t2_sel3", wb_sel, 3);
    check("t2_rd7", wb_rd, 7);
    sv[3] = 1'b0;
    cycle();
    check("t2_ready1", last_dut_ready, 5'b00010);
    check("t2_sel1", wb_sel, 1);
    sv[1] = 1'b0;

    // 3: stall holds output, release grants in the same cycle
    wb_ready = 1'b0; sv = 5'b10000; sd[4] = 32'h4444; sr[4] = 9;
    repeat (3) cycle();
    check("t3_hold_sel", wb_sel, 1);
    check("t3_hold_valid", wb_valid, 1);
    wb_ready = 1'b1;
    cycle();
    check("t3_sel4", wb_sel, 4);
    check("t3_valid", wb_valid, 1);
    sv = '0;

    // 4: rd==0 accepted but not written
    sv = 5'b00001; sr[0] = 0; sd[0] = 32'hDEAD;
    cycle();
    check("t4_ready0", last_dut_ready, 5'b00001);
    check("t4_novalid", wb_valid, 0);
    sv = '0;
    cycle();

    // 5: src4 keeps re-requesting while src0 waits
    sv = 5'b10001; sr[0] = 1; sd[0] = 32'hA0; sr[4] = 2;
    first0 = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (last_dut_ready[0] && first0 < 0) first0 = k;
      if (last_gnt[4]) sd[4] = $urandom;
      if (last_gnt[0]) sd[0] = $urandom;
    end
`ifdef WB_ARB_AGE_EN
    check("t5_first_src0", first0, 5);
`else
    check("t5_src0_starved", first0, -1);
`endif
    sv = '0;
    cycle();

    // 6: reset while output pending and src2 waiting
    sv = 5'b00010; sr[1] = 5; wb_ready = 1'b1;
    cycle();
    sv = 5'b00100; sr[2] = 6; sd[2] = 32'h2222; wb_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("t6_rst_valid", wb_valid, 0);
    rst = 1'b0;
    cycle();
    check("t6_ready2", last_dut_ready, 5'b00100);
    check("t6_sel2", wb_sel, 2);
    sv = '0;
    cycle();

    // Randomized traffic honouring the hold-until-ready contract
    last_gnt = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) sv[i] = 1'b0;
        if (!sv[i] && ($urandom % 3 == 0)) begin
          sv[i] = 1'b1;
          sd[i] = $urandom;
          sr[i] = RW'($urandom % 32);
        end
      end
      wb_ready = ($urandom % 4) != 0;
      rst      = ($urandom % 60) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
